// File: rtl/red_pitaya_pid_avg_pkg.sv
// -----------------------------------------------------------------------------
// red_pitaya_pid_avg_pkg
// Shared definitions for the boxcar pre-filter in front of the MIMO PID:
//   - default sample width and maximum window depth
//   - accumulator width helper
//   - window-length clamp helper
// -----------------------------------------------------------------------------
package red_pitaya_pid_avg_pkg;

    localparam int AVG_DW    = 14;  // sample width, signed two's complement
    localparam int AVG_LOG2N = 4;   // log2 of the maximum window depth

    // The accumulator holds at most 2^log2n samples of dw bits each,
    // so dw+log2n bits can never overflow.
    function automatic int sum_width(input int dw, input int log2n);
        return dw + log2n;
    endfunction

    // Requested log2 window length, capped at the buffer depth.
    function automatic int clamp_len(input int len, input int log2n);
        return (len > log2n) ? log2n : len;
    endfunction

endpackage

// File: rtl/red_pitaya_avg_ram.sv
// -----------------------------------------------------------------------------
// red_pitaya_avg_ram
// N x DW circular sample buffer: one synchronous write port and one
// asynchronous read port, suited to distributed RAM. Contents are not reset.
//   clk_i    : write clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address (combinational read)
//   rdata_o  : read data
// -----------------------------------------------------------------------------
module red_pitaya_avg_ram #(
    parameter int DW = 14,
    parameter int AW = 4
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read sees the pre-write value when raddr == waddr in the same cycle,
    // which is exactly the sample about to be overwritten (the oldest one).
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/red_pitaya_pid_avg.sv
// -----------------------------------------------------------------------------
// red_pitaya_pid_avg
// Boxcar (moving-average) pre-filter between the ADC path and the PID input.
// Averages the last L = 2^min(len_i, LOG2N) signed samples, floor rounding.
//   clk_i     : ADC-domain clock
//   rst_i     : asynchronous active-high reset
//   dat_i     : input sample (signed)
//   dat_vld_i : input strobe, may be high every cycle
//   len_i     : log2 window length select (clamped to LOG2N)
//   clr_i     : synchronous window flush (wins over dat_vld_i)
//   dat_o     : averaged sample (signed), held between strobes
//   dat_vld_o : one-cycle strobe per new average
//   full_o    : window filled, averages valid; cleared by any flush
// Stream interface: dat_vld_i is a pure valid strobe with no ready; every
// strobed sample is accepted unless clr_i is high in the same cycle.
// Timing: sample in cycle t -> sum in t+1 -> dat_o/dat_vld_o in t+2.
// -----------------------------------------------------------------------------
module red_pitaya_pid_avg
    import red_pitaya_pid_avg_pkg::*;
#(
    parameter int DW    = AVG_DW,
    parameter int LOG2N = AVG_LOG2N
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [DW-1:0] dat_i,
    input  logic          dat_vld_i,
    input  logic [3:0]    len_i,
    input  logic          clr_i,
    output logic [DW-1:0] dat_o,
    output logic          dat_vld_o,
    output logic          full_o
);

    localparam int SW = sum_width(DW, LOG2N);
    localparam int AW = LOG2N;
    localparam int LW = $clog2(LOG2N + 1);
    localparam int CW = AW + 1;             // fill count spans 0..N

    // State
    logic [AW-1:0]        wptr_q, wptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic signed [SW-1:0] sum_q, sum_d;
    logic [LW-1:0]        len_q, len_d;
    logic                 pend_q, pend_d;   // sum_q holds a full-window total
    logic [DW-1:0]        dat_q, dat_d;
    logic                 vld_q, vld_d;
    logic                 full_q, full_d;

    // Datapath helpers
    logic [LW-1:0]        len_eff;
    logic [CW-1:0]        win_len;
    logic [AW-1:0]        rd_addr;
    logic [DW-1:0]        oldest;
    logic signed [SW-1:0] din_ext;
    logic signed [SW-1:0] old_ext;
    logic                 accept;
    logic                 len_chg;
    logic                 flush;
    logic                 at_full;

    red_pitaya_avg_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (accept),
        .waddr_i (wptr_q),
        .wdata_i (dat_i),
        .raddr_i (rd_addr),
        .rdata_o (oldest)
    );

    always_comb begin
        len_eff = LW'(clamp_len(int'(len_i), LOG2N));
        win_len = CW'(1) << len_eff;
        // L == N truncates to 0, i.e. the slot about to be overwritten.
        rd_addr = wptr_q - win_len[AW-1:0];
        din_ext = {{LOG2N{dat_i[DW-1]}}, dat_i};
        old_ext = {{LOG2N{oldest[DW-1]}}, oldest};

        accept  = dat_vld_i && !clr_i;
        len_chg = accept && (len_eff != len_q);
        flush   = clr_i || len_chg;
        at_full = (cnt_q == win_len);

        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        sum_d  = sum_q;
        len_d  = len_q;
        pend_d = 1'b0;
        dat_d  = dat_q;
        vld_d  = 1'b0;
        full_d = full_q;

        // Accumulator stage
        if (clr_i) begin
            sum_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            wptr_d = wptr_q + AW'(1);
            len_d  = len_eff;
            if (len_chg) begin
                // The len-change sample starts the new window.
                sum_d = din_ext;
                cnt_d = CW'(1);
            end else begin
                sum_d = sum_q + din_ext - (at_full ? old_ext : '0);
                cnt_d = at_full ? cnt_q : cnt_q + CW'(1);
            end
            pend_d = (cnt_d == win_len);
        end

        // Output stage; a flush discards any average still in flight.
        if (flush) begin
            full_d = 1'b0;
        end else if (pend_q) begin
            dat_d  = DW'(sum_q >>> len_q);
            vld_d  = 1'b1;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            cnt_q  <= '0;
            sum_q  <= '0;
            len_q  <= '0;
            pend_q <= 1'b0;
            dat_q  <= '0;
            vld_q  <= 1'b0;
            full_q <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
            sum_q  <= sum_d;
            len_q  <= len_d;
            pend_q <= pend_d;
            dat_q  <= dat_d;
            vld_q  <= vld_d;
            full_q <= full_d;
        end
    end

    assign dat_o     = dat_q;
    assign dat_vld_o = vld_q;
    assign full_o    = full_q;

endmodule
